pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter and fetch-sequencing stage of the single-cycle MIPS CPU.
- Consumes the decoder's control-flow outputs (Jmp, Jr, Beq, Bne, Syscall) and the register-file/ALU compare results.
- Each cycle it produces the PC and instruction-memory word address that feed the next instruction fetch.
- Implements syscall halt/resume and display latching, plus the cycle, jump and taken-branch statistics counters shown on the board display.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- IMEM_AW, 10, instruction-memory word-address width.
- SYS_HALT, 32'd10, $v0 value that makes syscall halt.
- SYS_DISP, 32'd34, $v0 value that makes syscall latch $a0 to the display.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  debounced resume button, level
- Jmp  in  1  unconditional jump (j, jal, jr)
- Jr  in  1  register jump; target from rs_data
- Beq  in  1  branch if equal
- Bne  in  1  branch if not equal
- Syscall  in  1  syscall instruction in execute
- equal  in  1  rs_data == rt_data compare result
- imm16  in  16  instruction[15:0]
- target26  in  26  instruction[25:0]
- rs_data  in  32  register file read port 1
- v0_data  in  32  $v0 contents
- a0_data  in  32  $a0 contents
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, used for jal link
- imem_addr  out  IMEM_AW  pc[IMEM_AW+1:2]
- halted  out  1  high while in HALT
- led_data  out  32  last value latched by display syscall
- cycle_cnt  out  32  executed-cycle counter
- jump_cnt  out  32  unconditional jump counter
- branch_cnt  out  32  taken conditional branch counter

Behaviour:
- Reset (rst high at posedge): state=RUN, pc=RESET_PC, led_data=0, all counters=0, halted=0, go_q=0. Reset applies identically when it arrives mid-HALT.
- go_q registers go every cycle. go_rise = go & ~go_q.
- Combinational next-PC, priority highest first:
  - Jr & Jmp: rs_data.
  - Jmp: {pc_plus4[31:28], target26, 2'b00}.
  - taken = (Beq & equal) | (Bne & ~equal): pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}.
  - Otherwise pc_plus4.
  - All adds are 32-bit and wrap modulo 2^32.
- State RUN, each cycle:
  - Syscall & v0_data==SYS_HALT: pc <= pc_plus4; state <= HALT.
  - Syscall & v0_data==SYS_DISP: led_data <= a0_data; pc <= pc_plus4.
  - Syscall with any other code: treated as a nop.
  - Otherwise: pc <= next-PC.
  - cycle_cnt += 1 every RUN cycle, including the halting syscall cycle.
  - jump_cnt += 1 when Jmp is high (includes jr and jal).
  - branch_cnt += 1 when taken is high.
  - go_rise in RUN is ignored.
- State HALT:
  - pc, led_data and all counters hold. halted=1.
  - go_rise: state <= RUN. The pc already points past the syscall, so execution resumes there on the next cycle.
  - If go is already held high when HALT is entered, no resume occurs until go falls and rises again.
- Control inputs are ignored while in HALT. The decoder keeps re-decoding the post-syscall instruction with no effect.
- Counters wrap 32'hFFFF_FFFF -> 0 silently.
- Simultaneous Syscall and Jmp/branch: not produced by the decoder. If it occurs, Syscall wins and pc <= pc_plus4.
- Latency: pc and imem_addr change one cycle after the controlling instruction is presented. pc_plus4 and imem_addr are purely combinational from pc.
- halted is a decode of the state register.

Decomposition:
- Shared header for the CPU: SYS_HALT and SYS_DISP codes, RESET_PC default, RUN/HALT state encodings.
- One combinational sub-module, next_pc_logic: inputs pc_plus4, Jmp, Jr, Beq, Bne, equal, imm16, target26, rs_data; outputs next_pc and taken.
- The state machine, PC register and counters stay in pc_sequencer.

Test Plan:
- Reset then 3 plain cycles -> pc = 0, 4, 8, C; imem_addr = 0, 1, 2, 3; cycle_cnt = 3.
- At pc=0x10: Beq=1, equal=1, imm16=0xFFFC -> pc=0x04, branch_cnt=1. Then Bne=1, equal=1 -> pc=0x08, branch_cnt unchanged.
- At pc=0x3000_0040: Jmp=1, target26=0x0000123 -> pc=0x3000_048C, jump_cnt+1. Then Jmp=Jr=1, rs_data=0x200 -> pc=0x200.
- Syscall with v0=34, a0=0xDEAD_BEEF at pc=0x20 -> led_data=0xDEAD_BEEF, pc=0x24, state stays RUN.
- Syscall with v0=10 at pc=0x30 -> halted=1, pc=0x34 and held for 20 cycles, cycle_cnt frozen. go held high from entry -> no resume. go low, then high -> RUN next cycle, pc advances from 0x34.
- rst asserted while halted with counters nonzero -> next cycle pc=RESET_PC, halted=0, counters=0, led_data=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU constants for the fetch sequencer: syscall service codes,
// the default reset vector and the run/halt state encoding.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] SYS_HALT_CODE    = 32'd10;
  localparam logic [31:0] SYS_DISP_CODE    = 32'd34;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for jumps, register jumps and
// conditional branches; also reports whether a branch was taken.
module next_pc_logic (
  input  logic [31:0] pc_plus4,
  input  logic        Jmp,
  input  logic        Jr,
  input  logic        Beq,
  input  logic        Bne,
  input  logic        equal,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        taken
);

  logic [31:0] branch_off;

  assign taken      = (Beq & equal) | (Bne & ~equal);
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (Jr && Jmp) begin
      next_pc = rs_data;
    end else if (Jmp) begin
      next_pc = {pc_plus4[31:28], target26, 2'b00};
    end else if (taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, syscall halt/resume and display latch, and the
// cycle/jump/branch statistics counters for the single-cycle CPU.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_AW  = 10,
  parameter logic [31:0] SYS_HALT = SYS_HALT_CODE,
  parameter logic [31:0] SYS_DISP = SYS_DISP_CODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               Jmp,
  input  logic               Jr,
  input  logic               Beq,
  input  logic               Bne,
  input  logic               Syscall,
  input  logic               equal,
  input  logic [15:0]        imm16,
  input  logic [25:0]        target26,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        v0_data,
  input  logic [31:0]        a0_data,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               halted,
  output logic [31:0]        led_data,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        jump_cnt,
  output logic [31:0]        branch_cnt
);

  seq_state_t  state;
  logic        go_q;
  logic        go_rise;
  logic [31:0] next_pc;
  logic        taken;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[IMEM_AW+1:2];
  assign halted    = (state == HALT);
  assign go_rise   = go & ~go_q;

  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4),
    .Jmp      (Jmp),
    .Jr       (Jr),
    .Beq      (Beq),
    .Bne      (Bne),
    .equal    (equal),
    .imm16    (imm16),
    .target26 (target26),
    .rs_data  (rs_data),
    .next_pc  (next_pc),
    .taken    (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      led_data   <= '0;
      cycle_cnt  <= '0;
      jump_cnt   <= '0;
      branch_cnt <= '0;
      go_q       <= 1'b0;
    end else begin
      // go_q tracks go in both states so a button held across HALT entry
      // must be released before it can resume.
      go_q <= go;
      case (state)
        RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (Jmp) jump_cnt <= jump_cnt + 32'd1;
          if (taken) branch_cnt <= branch_cnt + 32'd1;
          if (Syscall) begin
            pc <= pc_plus4;
            if (v0_data == SYS_HALT) begin
              state <= HALT;
            end else if (v0_data == SYS_DISP) begin
              led_data <= a0_data;
            end
          end else begin
            pc <= next_pc;
          end
        end
        HALT: begin
          if (go_rise) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: branches, jumps, syscalls, halt/resume
// and mid-halt reset, with hand-computed expected values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        Jmp, Jr, Beq, Bne, Syscall, equal;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_data, v0_data, a0_data;
  logic [31:0] pc, pc_plus4;
  logic [9:0]  imem_addr;
  logic        halted;
  logic [31:0] led_data, cycle_cnt, jump_cnt, branch_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (10),
    .SYS_HALT (32'd10),
    .SYS_DISP (32'd34)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .Jmp        (Jmp),
    .Jr         (Jr),
    .Beq        (Beq),
    .Bne        (Bne),
    .Syscall    (Syscall),
    .equal      (equal),
    .imm16      (imm16),
    .target26   (target26),
    .rs_data    (rs_data),
    .v0_data    (v0_data),
    .a0_data    (a0_data),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .imem_addr  (imem_addr),
    .halted     (halted),
    .led_data   (led_data),
    .cycle_cnt  (cycle_cnt),
    .jump_cnt   (jump_cnt),
    .branch_cnt (branch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic clear_ctl();
    Jmp = 0; Jr = 0; Beq = 0; Bne = 0; Syscall = 0; equal = 0;
    imm16 = '0; target26 = '0; rs_data = '0; v0_data = '0; a0_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jr_to(input logic [31:0] addr);
    clear_ctl();
    Jmp = 1; Jr = 1; rs_data = addr;
    tick();
    clear_ctl();
  endtask

  initial begin
    clear_ctl();
    rst = 1; go = 0;
    tick(); tick();
    rst = 0;
    check("rst_pc", pc, 32'h0);
    check("rst_imem", {22'd0, imem_addr}, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'h0);
    check("rst_cycle", cycle_cnt, 32'h0);
    check("rst_jump", jump_cnt, 32'h0);
    check("rst_branch", branch_cnt, 32'h0);
    check("rst_led", led_data, 32'h0);
    check("rst_plus4", pc_plus4, 32'h4);

    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", pc, 32'(4 * i));
      check("seq_imem", {22'd0, imem_addr}, 32'(i));
    end
    check("seq_cycle", cycle_cnt, 32'd3);

    jr_to(32'h10);
    check("jr10_pc", pc, 32'h10);
    check("jr10_jump", jump_cnt, 32'd1);

    Beq = 1; equal = 1; imm16 = 16'hFFFC;
    tick(); clear_ctl();
    check("beq_pc", pc, 32'h04);
    check("beq_branch", branch_cnt, 32'd1);

    Bne = 1; equal = 1; imm16 = 16'hFFFC;
    tick(); clear_ctl();
    check("bne_nt_pc", pc, 32'h08);
    check("bne_nt_branch", branch_cnt, 32'd1);

    Bne = 1; equal = 0; imm16 = 16'h0004;
    tick(); clear_ctl();
    check("bne_t_pc", pc, 32'h1C);
    check("bne_t_branch", branch_cnt, 32'd2);

    Beq = 1; equal = 0; imm16 = 16'h0100;
    tick(); clear_ctl();
    check("beq_nt_pc", pc, 32'h20);
    check("beq_nt_cycle", cycle_cnt, 32'd8);

    Syscall = 1; v0_data = 32'd34; a0_data = 32'hDEAD_BEEF;
    tick(); clear_ctl();
    check("disp_led", led_data, 32'hDEAD_BEEF);
    check("disp_pc", pc, 32'h24);
    check("disp_halted", {31'd0, halted}, 32'h0);

    Syscall = 1; v0_data = 32'd5; a0_data = 32'h1234_5678;
    tick(); clear_ctl();
    check("nop_sys_pc", pc, 32'h28);
    check("nop_sys_led", led_data, 32'hDEAD_BEEF);

    jr_to(32'h30);
    check("jr30_jump", jump_cnt, 32'd2);
    check("jr30_cycle", cycle_cnt, 32'd11);

    go = 1;
    Syscall = 1; v0_data = 32'd10;
    tick(); clear_ctl();
    check("halt_halted", {31'd0, halted}, 32'h1);
    check("halt_pc", pc, 32'h34);
    check("halt_cycle", cycle_cnt, 32'd12);

    Jmp = 1; Jr = 1; rs_data = 32'h999; Beq = 1; equal = 1;
    Syscall = 1; v0_data = 32'd34; a0_data = 32'h5555_5555;
    for (int i = 0; i < 20; i++) tick();
    check("hold_pc", pc, 32'h34);
    check("hold_halted", {31'd0, halted}, 32'h1);
    check("hold_cycle", cycle_cnt, 32'd12);
    check("hold_jump", jump_cnt, 32'd2);
    check("hold_branch", branch_cnt, 32'd2);
    check("hold_led", led_data, 32'hDEAD_BEEF);

    go = 0;
    tick();
    check("golow_halted", {31'd0, halted}, 32'h1);
    go = 1;
    tick();
    check("resume_halted", {31'd0, halted}, 32'h0);
    check("resume_pc", pc, 32'h34);
    clear_ctl();
    go = 0;
    tick();
    check("after_pc", pc, 32'h38);
    check("after_cycle", cycle_cnt, 32'd13);

    Syscall = 1; v0_data = 32'd10;
    tick(); clear_ctl();
    check("halt2_halted", {31'd0, halted}, 32'h1);
    check("halt2_pc", pc, 32'h3C);
    rst = 1;
    tick();
    rst = 0;
    check("hrst_pc", pc, 32'h0);
    check("hrst_halted", {31'd0, halted}, 32'h0);
    check("hrst_cycle", cycle_cnt, 32'h0);
    check("hrst_jump", jump_cnt, 32'h0);
    check("hrst_branch", branch_cnt, 32'h0);
    check("hrst_led", led_data, 32'h0);

    jr_to(32'h3000_0040);
    Jmp = 1; target26 = 26'h0000123;
    tick(); clear_ctl();
    check("j_pc", pc, 32'h3000_048C);
    check("j_imem", {22'd0, imem_addr}, 32'h123);
    check("j_jump", jump_cnt, 32'd2);

    Jmp = 1; Jr = 1; rs_data = 32'h200; target26 = 26'h3FFFFFF;
    tick(); clear_ctl();
    check("jr200_pc", pc, 32'h200);
    check("jr200_jump", jump_cnt, 32'd3);
    check("jr200_cycle", cycle_cnt, 32'd3);

    jr_to(32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    tick();
    check("wrap_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
